// File: rtl/uart_io_if.sv
// uart_io_if
// Byte-wide IO port between the MMU and the UART endpoint.
//   io_in_data/io_in_vld/io_in_rdy    : received byte, device -> MMU
//   io_out_data/io_out_vld/io_out_rdy : byte to transmit, MMU -> device
//   io_err                            : sticky receive error flags
//                                       {resp1, parity, frame, overrun, lost}
// master = MMU side, slave = UART endpoint side.
interface uart_io_if;
    logic [7:0] io_in_data;
    logic       io_in_vld;
    logic       io_in_rdy;
    logic [7:0] io_out_data;
    logic       io_out_vld;
    logic       io_out_rdy;
    logic [4:0] io_err;

    modport master (
        input  io_in_data, io_in_vld, io_out_rdy, io_err,
        output io_in_rdy, io_out_data, io_out_vld
    );

    modport slave (
        output io_in_data, io_in_vld, io_out_rdy, io_err,
        input  io_in_rdy, io_out_data, io_out_vld
    );
endinterface

// File: rtl/uart_io.sv
// uart_io
// 8N1 UART endpoint on the device side of the MMU byte port.
// Ports:
//   clk      : system clock
//   rstn     : synchronous active-low reset
//   uart_rx  : serial input pin (asynchronous, idle high)
//   uart_tx  : serial output pin (idle high)
//   io       : uart_io_if.slave -- RX byte out, TX byte in, sticky error flags
// Parameter CLK_PER_BIT: clock cycles per serial bit (>= 4).
//
// RX states:
//   R_IDLE  | waiting for a start edge
//   R_START | half-bit wait, then confirm the start bit
//   R_DATA  | sampling 8 data bits LSB first
//   R_STOP  | sampling the stop bit
//   R_BREAK | framing error, waiting for the line to return high
// TX states:
//   T_IDLE  | ready for a byte
//   T_START | driving the start bit
//   T_DATA  | driving 8 data bits LSB first
//   T_STOP  | driving the stop bit
module uart_io #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     uart_rx,
    output logic     uart_tx,
    uart_io_if.slave io
);
    localparam int TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID  = TW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    rx_state_t     rx_state;
    logic [TW-1:0] rx_timer;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_m;
    logic          rx_s;
    logic [7:0]    in_data;
    logic          in_vld;
    logic [2:0]    err;    // {frame, overrun, lost}

    tx_state_t     tx_state;
    logic [TW-1:0] tx_timer;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_byte;
    logic          out_rdy;

    assign io.io_in_data = in_data;
    assign io.io_in_vld  = in_vld;
    assign io.io_out_rdy = out_rdy;
    assign io.io_err     = {2'b00, err};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state <= R_IDLE;
            rx_timer <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            in_data  <= '0;
            in_vld   <= 1'b0;
            err      <= '0;
        end else begin
            // Clear on the read edge first; any error set below in the same
            // cycle overrides the clear.
            if (in_vld && io.io_in_rdy) begin
                in_vld <= 1'b0;
                err    <= '0;
            end
            case (rx_state)
                R_IDLE: begin
                    if (!rx_s) begin
                        rx_timer <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_timer == T_MID) begin
                        rx_timer <= '0;
                        if (!rx_s) begin
                            rx_idx   <= '0;
                            rx_state <= R_DATA;
                        end else begin
                            err[0]   <= 1'b1;
                            rx_state <= R_IDLE;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_timer == T_LAST) begin
                        rx_timer <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) rx_state <= R_STOP;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_timer == T_LAST) begin
                        rx_timer <= '0;
                        if (rx_s) begin
                            // Old byte wins on overrun; leave at mid-stop so a
                            // back-to-back start edge is not missed.
                            if (in_vld) begin
                                err[1] <= 1'b1;
                            end else begin
                                in_data <= rx_shift;
                                in_vld  <= 1'b1;
                            end
                            rx_state <= R_IDLE;
                        end else begin
                            err[2]   <= 1'b1;
                            rx_state <= R_BREAK;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (rx_s) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= T_IDLE;
            tx_timer <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            uart_tx  <= 1'b1;
            out_rdy  <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (out_rdy && io.io_out_vld) begin
                        tx_byte  <= io.io_out_data;
                        out_rdy  <= 1'b0;
                        uart_tx  <= 1'b0;
                        tx_timer <= '0;
                        tx_state <= T_START;
                    end else begin
                        out_rdy <= 1'b1;
                    end
                end
                T_START: begin
                    if (tx_timer == T_LAST) begin
                        tx_timer <= '0;
                        tx_idx   <= '0;
                        uart_tx  <= tx_byte[0];
                        tx_state <= T_DATA;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                T_DATA: begin
                    if (tx_timer == T_LAST) begin
                        tx_timer <= '0;
                        if (tx_idx == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= T_STOP;
                        end else begin
                            tx_idx  <= tx_idx + 3'd1;
                            uart_tx <= tx_byte[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                T_STOP: begin
                    // Ready is re-raised by T_IDLE one cycle after the stop bit.
                    if (tx_timer == T_LAST) begin
                        tx_timer <= '0;
                        tx_state <= T_IDLE;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_io.sv
// tb_uart_io
// Directed + randomized bench for uart_io with CLK_PER_BIT = 16.
// A small behavioural model tracks the RX holding byte and error flags;
// TX frames are checked against the 8N1 bit sequence of each byte.
module tb_uart_io;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    uart_io_if io ();

    uart_io #(.CLK_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .io      (io)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // RX reference model
    logic       m_vld;
    logic [7:0] m_data;
    logic [2:0] m_err;   // {frame, overrun, lost}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        logic [9:0]  frame;
        logic [15:0] v;
        int          t;
        int          low;
        frame = {1'b1, b, 1'b0};
        t = 0;
        while (!io.io_out_rdy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("tx_rdy_wait", io.io_out_rdy, 1);
        io.io_out_data = b;
        io.io_out_vld  = 1'b1;
        @(negedge clk);
        io.io_out_vld  = 1'b0;
        io.io_out_data = 8'($urandom);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                v[j] = uart_tx;
                if (!io.io_out_rdy) low++;
                @(negedge clk);
            end
            check($sformatf("tx_%02h_bit%0d", b, k), v, {16{frame[k]}});
        end
        check("tx_idle_after", uart_tx, 1);
        while (!io.io_out_rdy && low < 400) begin
            low++;
            @(negedge clk);
        end
        check("tx_rdy_low_cycles", low, 161);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                uart_rx = bits[k];
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        if (!stop_ok)      m_err[2] = 1'b1;
        else if (m_vld)    m_err[1] = 1'b1;
        else begin
            m_vld  = 1'b1;
            m_data = b;
        end
    endtask

    task automatic rx_compare(input string tag);
        check({tag, "_vld"},  io.io_in_vld,  m_vld);
        check({tag, "_data"}, io.io_in_data, m_data);
        check({tag, "_err"},  io.io_err,     {2'b00, m_err});
    endtask

    task automatic rx_read(input string tag);
        io.io_in_rdy = 1'b1;
        @(negedge clk);
        io.io_in_rdy = 1'b0;
        if (m_vld) begin
            m_vld = 1'b0;
            m_err = '0;
        end
        rx_compare(tag);
    endtask

    initial begin
        logic [7:0] b;
        m_vld  = 1'b0;
        m_data = '0;
        m_err  = '0;
        io.io_in_rdy   = 1'b0;
        io.io_out_vld  = 1'b0;
        io.io_out_data = '0;

        repeat (3) @(negedge clk);
        check("reset_tx",   uart_tx,        1);
        check("reset_rdy",  io.io_out_rdy,  0);
        check("reset_vld",  io.io_in_vld,   0);
        check("reset_data", io.io_in_data,  0);
        check("reset_err",  io.io_err,      0);
        rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", io.io_out_rdy, 1);

        tx_byte(8'hA5);
        tx_byte(8'($urandom));
        tx_byte(8'($urandom));

        // Reset during the data bits of 0xFF
        io.io_out_data = 8'hFF;
        io.io_out_vld  = 1'b1;
        @(negedge clk);
        io.io_out_vld = 1'b0;
        repeat (40) @(negedge clk);
        check("midtx_rdy_busy", io.io_out_rdy, 0);
        rstn = 1'b0;
        @(negedge clk);
        check("midtx_reset_tx",  uart_tx,       1);
        check("midtx_reset_rdy", io.io_out_rdy, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("midtx_release_rdy", io.io_out_rdy, 1);
        repeat (20) @(negedge clk);
        check("midtx_line_idle", uart_tx, 1);
        tx_byte(8'h3C);

        // RX single byte
        rx_frame(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        rx_compare("rx_3c");
        rx_read("rx_3c_read");

        // Randomized RX frames with random reads
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            rx_frame(b, 1'b1);
            repeat (2) @(negedge clk);
            rx_compare($sformatf("rx_rand%0d", i));
            if ($urandom_range(0, 1) == 1) rx_read($sformatf("rx_rand%0d_read", i));
        end
        if (m_vld) rx_read("rx_drain");

        // Overrun: two back-to-back frames, no read
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        rx_compare("rx_overrun");
        rx_read("rx_overrun_read");

        // Framing error: stop bit low, line low 40 cycles from stop bit start
        rx_frame(8'h55, 1'b0);
        uart_rx = 1'b0;
        repeat (40 - CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        rx_compare("rx_frame_err");
        rx_frame(8'h66, 1'b1);
        repeat (2) @(negedge clk);
        rx_compare("rx_after_frame");
        rx_read("rx_after_frame_read");

        // False start: 4-cycle low glitch
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        m_err[0] = 1'b1;
        rx_compare("rx_false_start");
        b = 8'($urandom);
        rx_frame(b, 1'b1);
        repeat (2) @(negedge clk);
        rx_compare("rx_after_glitch");
        rx_read("rx_after_glitch_read");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
